clk_prescaler: RTL and testbench

- Producer end of the `clk_ena` interface consumed by the 8-bit timer counter.
- Divides the system clock by a software-selected power of two using a free-running binary counter plus rising-edge detection.
- Emits a registered one-cycle `clk_ena` strobe.
- Sits between the timer control register (source of `cks`/`en`) and the counter.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/clk_prescaler_edge.sv | 44 ++++
 rtl/clk_prescaler.sv | 80 ++++++++
 tb/tb_clk_prescaler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer block: default prescaler sizing, named
// clock-select codes and the restart latency of the divider pipeline.
package timer_pkg;

  localparam int DIV_W_DEF = 4;
  localparam int CKS_W_DEF = 3;

  localparam logic [CKS_W_DEF-1:0] CKS_DIRECT = 3'd0;
  localparam logic [CKS_W_DEF-1:0] CKS_DIV2   = 3'd1;
  localparam logic [CKS_W_DEF-1:0] CKS_DIV4   = 3'd2;
  localparam logic [CKS_W_DEF-1:0] CKS_DIV8   = 3'd3;
  localparam logic [CKS_W_DEF-1:0] CKS_DIV16  = 3'd4;

  // Cycles between the counter bit rising and clk_ena going high:
  // one for the edge register, one for the output register.
  localparam int RESTART_LAT = 2;

  // Posedge (counted from the restart edge) after which the first strobe
  // of divide-by-2^k appears.
  function automatic int first_pulse_cycle(input int k);
    return (1 << (k - 1)) + RESTART_LAT;
  endfunction

endpackage

// File: rtl/clk_prescaler_edge.sv
// Free-running divide counter with per-bit rising-edge detection.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   i_clr   synchronous clear of counter, delayed copy and edge flags
//   i_en    advance the counter; when low the counter holds and the
//           delayed copy / edge flags clear
//   o_edge  registered one-cycle flag per counter bit rising 0->1
module clk_prescaler_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_edge
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_cnt_d1;
  logic [W-1:0] r_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_cnt_d1 <= '0;
      r_edge   <= '0;
    end else if (i_clr) begin
      r_cnt    <= '0;
      r_cnt_d1 <= '0;
      r_edge   <= '0;
    end else if (i_en) begin
      r_cnt    <= r_cnt + 1'b1;
      r_cnt_d1 <= r_cnt;
      r_edge   <= r_cnt & ~r_cnt_d1;
    end else begin
      // Counter holds; pipeline flushed so nothing stale leaks out.
      r_cnt_d1 <= '0;
      r_edge   <= '0;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/clk_prescaler.sv
// Power-of-two clock prescaler producing a registered one-cycle clk_ena
// strobe for the timer counter.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   en       prescaler enable; low freezes the divider, forces clk_ena low
//   cks      clock select: 0 = every clock, k = divide by 2^k, >DIV_W reserved
//   clk_ena  registered one-cycle enable strobe
//   cks_err  registered flag, high while a reserved select is latched
module clk_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CKS_W = CKS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CKS_W-1:0] cks,
  output logic             clk_ena,
  output logic             cks_err
);

  logic [CKS_W-1:0] r_cks_q;
  logic             r_en_d1;
  logic             r_clk_ena;
  logic             r_cks_err;

  logic             w_sel_chg;
  logic             w_en_rise;
  logic             w_clr;
  logic [DIV_W-1:0] w_edge;
  logic             w_ena_nxt;

  assign w_sel_chg = (cks != r_cks_q);
  // Re-enable restarts the divider; otherwise a bit held at 1 while
  // disabled would look like a fresh edge.
  assign w_en_rise = en & ~r_en_d1;
  assign w_clr     = w_sel_chg | w_en_rise;

  clk_prescaler_edge #(
    .W (DIV_W)
  ) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (en),
    .o_edge (w_edge)
  );

  always_comb begin
    w_ena_nxt = 1'b0;
    if (!w_sel_chg && en) begin
      if (r_cks_q == '0) begin
        w_ena_nxt = 1'b1;
      end else begin
        for (int j = 0; j < DIV_W; j++) begin
          if (r_cks_q == CKS_W'(j + 1)) w_ena_nxt = w_edge[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cks_q   <= '0;
      r_en_d1   <= 1'b0;
      r_clk_ena <= 1'b0;
      r_cks_err <= 1'b0;
    end else begin
      r_cks_q   <= cks;
      r_en_d1   <= en;
      r_clk_ena <= w_ena_nxt;
      r_cks_err <= (r_cks_q > CKS_W'(DIV_W));
    end
  end

  assign clk_ena = r_clk_ena;
  assign cks_err = r_cks_err;

endmodule

// File: tb/tb_clk_prescaler.sv
module tb_clk_prescaler;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] cks = 3'd0;
  logic       clk_ena;
  logic       cks_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: select in effect, previous enable, and the
  // number of enabled posedges since the last restart edge.
  int m_cks = 0;
  bit m_en_prev = 1'b0;
  int m_t = 0;

  clk_prescaler #(.DIV_W(DIV), .CKS_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cks     (cks),
    .clk_ena (clk_ena),
    .cks_err (cks_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cks;
    int         ncyc;
    int         exp_pulses;
    int         exp_first;
    bit         exp_err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pulse_due(input int k, input int t);
    int first;
    int per;
    first = (1 << (k - 1)) + 2;
    per   = 1 << k;
    return (t >= first) && (((t - first) % per) == 0);
  endfunction

  // One posedge: advance the model from the inputs seen at that edge, then
  // compare both outputs shortly after the edge.
  task automatic step();
    bit chg;
    bit rise;
    bit exp_ena;
    bit exp_err;
    @(posedge clk);
    chg  = (int'(cks) != m_cks);
    rise = en && !m_en_prev;
    if (chg || rise) m_t = 0;
    else if (en) m_t++;
    exp_ena = 1'b0;
    if (!chg && en) begin
      if (m_cks == 0) exp_ena = 1'b1;
      else if (m_cks <= DIV) exp_ena = pulse_due(m_cks, m_t);
    end
    exp_err   = (m_cks > DIV);
    m_cks     = int'(cks);
    m_en_prev = en;
    #1;
    check("model_clk_ena", int'(clk_ena), int'(exp_ena));
    check("model_cks_err", int'(cks_err), int'(exp_err));
  endtask

  // Hold reset for n cycles with the current en/cks, outputs must stay low,
  // then release between edges.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    m_cks = 0;
    m_en_prev = 1'b0;
    m_t = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_clk_ena", int'(clk_ena), 0);
      check("rst_cks_err", int'(cks_err), 0);
    end
    rst_n = 1'b1;
  endtask

  // Expect pulses at offsets 3,5,7 (divide-by-2 restart) over 9 posedges,
  // where offset 0 is the restart edge.
  task automatic expect_div2_restart(input string name);
    for (int o = 0; o < 9; o++) begin
      step();
      check(name, int'(clk_ena), int'(o == 3 || o == 5 || o == 7));
    end
  endtask

  vec_t vecs[6];

  initial begin
    int pulses;
    int first;
    bit found;

    vecs[0] = '{3'd2, 41, 10, 4,  1'b0};
    vecs[1] = '{3'd0, 20, 20, 0,  1'b0};
    vecs[2] = '{3'd4, 60, 4,  10, 1'b0};
    vecs[3] = '{3'd1, 20, 9,  3,  1'b0};
    vecs[4] = '{3'd3, 30, 3,  6,  1'b0};
    vecs[5] = '{3'd6, 64, 0,  -1, 1'b1};

    // Table: select held through reset, count pulses after release.
    for (int v = 0; v < 6; v++) begin
      en  = 1'b1;
      cks = vecs[v].cks;
      do_reset(5);
      pulses = 0;
      first  = -1;
      for (int s = 0; s < vecs[v].ncyc; s++) begin
        step();
        if (clk_ena) begin
          pulses++;
          if (first < 0) first = s;
        end
        if (vecs[v].cks == 3'd6 && s == 1)
          check("reserved_err_second_cycle", int'(cks_err), 1);
      end
      check($sformatf("tbl%0d_pulses", v), pulses, vecs[v].exp_pulses);
      check($sformatf("tbl%0d_first", v), first, vecs[v].exp_first);
      check($sformatf("tbl%0d_err", v), int'(cks_err), int'(vecs[v].exp_err));
    end

    // Select change two cycles after a divide-by-4 pulse.
    en  = 1'b1;
    cks = 3'd2;
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clk_ena) begin
        found = 1'b1;
        break;
      end
    end
    check("selchg_found_pulse", int'(found), 1);
    step();
    cks = 3'd1;
    expect_div2_restart("selchg_pattern");

    // Enable gating with divide-by-8.
    en  = 1'b1;
    cks = 3'd3;
    do_reset(3);
    repeat (10) step();
    en = 1'b0;
    pulses = 0;
    repeat (20) begin
      step();
      if (clk_ena) pulses++;
    end
    check("disabled_pulses", pulses, 0);
    en = 1'b1;
    for (int o = 0; o < 23; o++) begin
      step();
      check("reenable_pattern", int'(clk_ena), int'(o == 6 || o == 14 || o == 22));
    end

    // Reserved code then back to divide-by-2.
    en  = 1'b1;
    cks = 3'd6;
    do_reset(3);
    repeat (10) step();
    check("reserved_err_set", int'(cks_err), 1);
    cks = 3'd1;
    step();
    check("reserved_err_hold", int'(cks_err), 1);
    step();
    check("reserved_err_clear", int'(cks_err), 0);
    for (int o = 2; o < 9; o++) begin
      step();
      check("reserved_exit_pattern", int'(clk_ena), int'(o == 3 || o == 5 || o == 7));
    end

    // Asynchronous reset while the strobe is high.
    en  = 1'b1;
    cks = 3'd1;
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clk_ena) begin
        found = 1'b1;
        break;
      end
    end
    check("async_found_pulse", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_drop", int'(clk_ena), 0);
    do_reset(2);
    expect_div2_restart("async_restart_pattern");

    // Randomised run against the reference model.
    en  = 1'b1;
    cks = 3'($urandom_range(0, 7));
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) cks = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
